// File: rtl/exu_muldiv_pkg.sv
// Shared types and constants for the M-extension sequencer.
// Op bit order, FSM states and fixed divide corner results.
package exu_muldiv_pkg;

  localparam int MULDIV_OP_W = 8;

  localparam int OP_MUL    = 0;
  localparam int OP_MULH   = 1;
  localparam int OP_MULHSU = 2;
  localparam int OP_MULHU  = 3;
  localparam int OP_DIV    = 4;
  localparam int OP_DIVU   = 5;
  localparam int OP_REM    = 6;
  localparam int OP_REMU   = 7;

  localparam logic [31:0] DIVZ_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;
  localparam logic [31:0] OVF_REM   = 32'h0000_0000;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Keep only the lowest set bit; an empty op decays to mul.
  function automatic logic [MULDIV_OP_W-1:0] op_norm(
    input logic [MULDIV_OP_W-1:0] op
  );
    logic [MULDIV_OP_W-1:0] r;
    r = '0;
    r[OP_MUL] = 1'b1;
    for (int i = MULDIV_OP_W - 1; i >= 0; i--) begin
      if (op[i]) begin
        r = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/exu_muldiv_ctrl_div_step.sv
// One restoring divide iteration on a {remainder, quotient} pair.
// Bit 32 of the partial remainder is kept so the shift never drops it.
module exu_div_step (
  input  logic [63:0] pair,
  input  logic [31:0] divisor,
  output logic [63:0] next
);

  logic [32:0] part;
  logic        ge;

  assign part = pair[63:31];
  assign ge   = part >= {1'b0, divisor};

  always_comb begin
    next = {part[31:0], pair[30:0], 1'b0};
    if (ge) begin
      next = {part[31:0] - divisor, pair[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/exu_muldiv_ctrl.sv
// M-extension sequencer: latches a request, stalls dispatch,
// runs a registered multiply or a restoring divide, writes back once.
module exu_muldiv_ctrl
  import exu_muldiv_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_muldiv_i,
  input  logic [31:0] muldiv_op1_i,
  input  logic [31:0] muldiv_op2_i,
  input  logic [7:0]  muldiv_op_i,
  input  logic [4:0]  rd_waddr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] result_o,
  output logic        busy_o
);

  localparam logic [4:0] CNT_LAST = 5'(DIV_ITERS - 1);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [7:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [63:0] pair_q;
  logic [31:0] res_q;

  logic [7:0]  op_n;
  logic        n_mul;
  logic        n_sdiv;
  logic        n_rem;
  logic        n_div0;
  logic        n_ovf;
  logic        accept;

  assign op_n   = op_norm(muldiv_op_i);
  assign n_mul  = |op_n[OP_MULHU:OP_MUL];
  assign n_sdiv = op_n[OP_DIV] | op_n[OP_REM];
  assign n_rem  = op_n[OP_REM] | op_n[OP_REMU];
  assign n_div0 = muldiv_op2_i == 32'd0;
  assign n_ovf  = n_sdiv && muldiv_op1_i == INT_MIN
               && muldiv_op2_i == 32'hFFFF_FFFF;
  assign accept = state_q == S_IDLE && req_muldiv_i && !flush_i;

  // Multiply on the latched operands, sign-extended to 33 bits.
  logic               a_sgn;
  logic               b_sgn;
  logic signed [32:0] ma;
  logic signed [32:0] mb;
  logic signed [63:0] prod;
  logic [31:0]        mul_res;

  assign a_sgn   = op_q[OP_MULH] | op_q[OP_MULHSU];
  assign b_sgn   = op_q[OP_MULH];
  assign ma      = {a_sgn & op1_q[31], op1_q};
  assign mb      = {b_sgn & op2_q[31], op2_q};
  assign prod    = 64'(ma) * 64'(mb);
  assign mul_res = (|op_q[OP_MULHU:OP_MULH]) ? prod[63:32]
                 : (op_q[OP_MUL] ? prod[31:0] : 32'd0);

  // Divide datapath works on magnitudes; sign restored on the last step.
  logic        q_sgn;
  logic [31:0] divisor;
  logic [63:0] pair_n;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] div_res;

  assign q_sgn   = op_q[OP_DIV] | op_q[OP_REM];
  assign divisor = q_sgn ? abs32(op2_q) : op2_q;

  exu_div_step u_step (
    .pair    (pair_q),
    .divisor (divisor),
    .next    (pair_n)
  );

  assign quo     = pair_n[31:0];
  assign rem     = pair_n[63:32];
  assign neg_q   = op_q[OP_DIV] & (op1_q[31] ^ op2_q[31]);
  assign neg_r   = op_q[OP_REM] & op1_q[31];
  assign div_res = (op_q[OP_DIV] | op_q[OP_DIVU])
                 ? (neg_q ? 32'd0 - quo : quo)
                 : (op_q[OP_REMU] | neg_r ? (neg_r ? 32'd0 - rem : rem)
                                          : rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      pair_q  <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q  <= op_n;
            rd_q  <= rd_waddr_i;
            op1_q <= muldiv_op1_i;
            op2_q <= muldiv_op2_i;
            cnt_q <= '0;
            pair_q <= {32'd0, n_sdiv ? abs32(muldiv_op1_i)
                                     : muldiv_op1_i};
            if (n_mul) begin
              state_q <= S_MUL;
            end else if (n_div0) begin
              res_q   <= n_rem ? muldiv_op1_i : DIVZ_QUOT;
              state_q <= S_DONE;
            end else if (n_ovf) begin
              res_q   <= n_rem ? OVF_REM : OVF_QUOT;
              state_q <= S_DONE;
            end else begin
              state_q <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            res_q   <= mul_res;
            state_q <= S_DONE;
          end
          cnt_q <= '0;
        end
        S_DIV: begin
          if (flush_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            pair_q  <= pair_n;
            res_q   <= div_res;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            pair_q <= pair_n;
            cnt_q  <= cnt_q + 5'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign stall_o = !flush_i && (
                     (state_q == S_IDLE && req_muldiv_i)
                   || state_q == S_MUL
                   || state_q == S_DIV);
  assign busy_o      = state_q != S_IDLE;
  assign reg_we_o    = state_q == S_DONE && !flush_i;
  assign reg_waddr_o = reg_we_o ? rd_q : 5'd0;
  assign result_o    = reg_we_o ? res_q : 32'd0;

endmodule

// File: tb/tb_exu_muldiv_ctrl.sv
// Self-checking bench for exu_muldiv_ctrl.
// Random and directed ops against an arithmetic reference model.
module tb_exu_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        req_muldiv;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [7:0]  op;
  logic [4:0]  rd;
  logic        flush;
  logic        stall;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] result;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  exu_muldiv_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_muldiv_i (req_muldiv),
    .muldiv_op1_i (op1),
    .muldiv_op2_i (op2),
    .muldiv_op_i  (op),
    .rd_waddr_i   (rd),
    .flush_i      (flush),
    .stall_o      (stall),
    .reg_we_o     (reg_we),
    .reg_waddr_o  (reg_waddr),
    .result_o     (result),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (req_muldiv && !rst) begin
      assert ($onehot(op));
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Results straight from RISC-V M-extension arithmetic rules.
  function automatic void ref_op(input int k,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] r,
                                 output int lat);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint p;
    logic   ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    lat = 33;
    r   = '0;
    case (k)
      0: begin p = sa * sb; r = p[31:0]; lat = 2; end
      1: begin p = sa * sb; r = p[63:32]; lat = 2; end
      2: begin p = sa * ub; r = p[63:32]; lat = 2; end
      3: begin p = ua * ub; r = p[63:32]; lat = 2; end
      4: begin
        if (b == 0) begin r = '1; lat = 1; end
        else if (ovf) begin r = a; lat = 1; end
        else begin p = sa / sb; r = p[31:0]; end
      end
      5: begin
        if (b == 0) begin r = '1; lat = 1; end
        else begin p = ua / ub; r = p[31:0]; end
      end
      6: begin
        if (b == 0) begin r = a; lat = 1; end
        else if (ovf) begin r = 0; lat = 1; end
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) begin r = a; lat = 1; end
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
  endfunction

  // Starts in the cycle after the caller's last sampled cycle.
  task automatic run_op(input int k, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d);
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    int          gaps;
    ref_op(k, a, b, exp, exp_lat);
    @(posedge clk);
    #1;
    req_muldiv = 1'b1;
    op  = 8'd1 << k;
    op1 = a;
    op2 = b;
    rd  = d;
    #1;
    chk("stall_req", 64'(stall), 64'd1);
    lat  = -1;
    gaps = 0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      req_muldiv = $urandom_range(0, 1);
      op1 = $urandom;
      op2 = $urandom;
      op  = 8'd1 << $urandom_range(0, 7);
      #1;
      if (reg_we) lat = c;
      else if (!stall) gaps++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("result", 64'(result), 64'(exp));
    chk("waddr", 64'(reg_waddr), 64'(d));
    chk("done_stall", 64'(stall), 64'd0);
    chk("stall_hold", 64'(gaps), 64'd0);
    req_muldiv = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  int we_cnt;

  initial begin
    rst = 1'b1;
    req_muldiv = 1'b0;
    op1 = '0;
    op2 = '0;
    op  = '0;
    rd  = '0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_we", 64'(reg_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    rst = 1'b0;

    run_op(0, 32'h7, 32'hFFFF_FFFD, 5'd5);
    run_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(2, 32'hFFFF_FFFF, 32'h2, 5'd3);
    run_op(4, 32'hFFFF_FFEC, 32'd3, 5'd4);
    run_op(6, 32'hFFFF_FFEC, 32'd3, 5'd6);
    run_op(5, 32'd100, 32'd7, 5'd7);
    run_op(7, 32'd100, 32'd7, 5'd8);
    run_op(4, 32'd5, 32'd0, 5'd9);
    run_op(7, 32'd5, 32'd0, 5'd10);
    run_op(4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

    // Flush a divide at cycle 10, then a mul issued at cycle 12.
    @(posedge clk);
    #1;
    req_muldiv = 1'b1;
    op  = 8'd1 << 5;
    op1 = 32'd1000;
    op2 = 32'd3;
    rd  = 5'd13;
    we_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      req_muldiv = 1'b0;
      if (reg_we) we_cnt++;
    end
    flush = 1'b1;
    #1;
    chk("flush_stall", 64'(stall), 64'd0);
    chk("flush_we", 64'(reg_we), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_idle_stall", 64'(stall), 64'd0);
    run_op(0, 32'd6, 32'd7, 5'd14);
    for (int c = 15; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (reg_we) we_cnt++;
    end
    chk("flush_no_write", 64'(we_cnt), 64'd0);

    // Reset in the middle of a divide.
    @(posedge clk);
    #1;
    req_muldiv = 1'b1;
    op  = 8'd1 << 4;
    op1 = 32'd77;
    op2 = 32'd5;
    rd  = 5'd15;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      req_muldiv = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_stall", 64'(stall), 64'd0);
    chk("mid_rst_we", 64'(reg_we), 64'd0);
    chk("mid_rst_res", 64'({reg_waddr, result}), 64'd0);
    run_op(5, 32'd9, 32'd3, 5'd16);

    for (int i = 0; i < 60; i++) begin
      run_op($urandom_range(0, 7), pick(), pick(),
             5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
